mips_dmem_arbiter: RTL and testbench
====================================

MIPS_DMEM_ARBITER -- requirements
Module: mips_dmem_arbiter

Interface
REQ-001 Parameter: RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority to port 0.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 reqN  input  1  (N=0,1) access request, level.
REQ-005 weN  input  1  1 = write, 0 = read.
REQ-006 addrN  input  32  byte address.
REQ-007 wdataN  input  32  write data, low bits used for half/byte.
REQ-008 bwN  input  2  byte width: 11 word, 10 half, 01 byte, 00 illegal.
REQ-009 sextN  input  1  sign-extend read data.
REQ-010 gntN  output  1  registered one-cycle pulse; request accepted.
REQ-011 rvalidN  output  1  registered one-cycle pulse; response valid.
REQ-012 rdataN  output  32  read data, valid with rvalidN.
REQ-013 errN  output  1  access error, valid with rvalidN.
REQ-014 m_addr, m_busw  output  32  memory address / write bus.
REQ-015 m_wen, m_sext  output  1  memory write enable / sign-extend.
REQ-016 m_bw  output  2  memory byte width.
REQ-017 m_busr  input  32  memory read bus (combinational from m_addr/m_bw/m_sext).
REQ-018 m_err  input  1  memory alignment error flag.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, RESP; IDLE->ACCESS when any req is high, ACCESS->RESP always, RESP->IDLE always.
REQ-020 In IDLE with a req high, the block SHALL latch the winner's we/addr/wdata/bw/sext at the clock edge; requesters' fields need only be valid in that cycle.
REQ-021 Latency: req sampled in cycle N -> gnt in N+1 (ACCESS) -> rvalid in N+2 (RESP); one access per 3 cycles max.
REQ-022 In ACCESS, m_addr/m_busw/m_bw/m_sext SHALL drive the latched command; m_wen = latched we & ~rst & (bw!=00), high for exactly that one cycle.
REQ-023 At the end of ACCESS, m_busr and m_err SHALL be captured into the winner's rdata/err registers; for writes rdata = 0.
REQ-024 bw=00: no memory write, RESP SHALL report err=1, rdata=0.
REQ-025 Outside ACCESS, m_wen = 0 and m_addr/m_busw/m_bw/m_sext = 0.
REQ-026 Requests in ACCESS/RESP SHALL be ignored; each IDLE cycle with req high starts a new access (requester drops req after gnt for a single access).
REQ-027 RR_EN=1: on simultaneous requests, grant the port not granted most recently; single requester always wins; pointer updates only on grant.
REQ-028 RR_EN=0: port 0 SHALL win every simultaneous request.
REQ-029 Only the granted port's gnt/rvalid/rdata/err SHALL change; the other port's rdata/err hold their values.

Reset
REQ-030 On rst: state IDLE, gnt/rvalid/rdata/err = 0, latched command = 0, RR pointer = "port 1 last" so port 0 wins first.
REQ-031 rst during ACCESS SHALL suppress m_wen that cycle (no memory write) and produce no rvalid.
REQ-032 rst during RESP SHALL clear rvalid in the following cycle; no retry.

Structure
REQ-033 Package mips_dmem_pkg SHALL hold state enum and constants BW_WORD=2'b11, BW_HALF=2'b10, BW_BYTE=2'b01, BW_NONE=2'b00.
REQ-034 Sub-module mips_rr_arb2 SHALL implement the 2-way picker (req[1:0], last, rr_en -> grant one-hot).

Verification
REQ-035 Port0 write addr 0x10 data 0xDEADBEEF bw 11, then read 0x10 -> m_wen high 1 cycle; rvalid0 with rdata0 0xDEADBEEF, err0 0, latency gnt+1.
REQ-036 Both req held after reset, RR_EN=1 -> grants 0,1,0,1; RR_EN=0 -> grants 0,0,0.
REQ-037 Port1 word read addr 0x12 -> rvalid1 with err1=1.
REQ-038 Memory word 0x000080FF, byte read addr 0x01 sext 1 -> rdata 0xFFFFFF80; sext 0 -> 0x00000080.
REQ-039 bw 00 write -> m_wen never high, err=1, rdata=0.
REQ-040 rst high in ACCESS of write 0x12345678 to 0x20 -> memory unchanged, no rvalid, state IDLE next cycle.

Source files
------------

// File: rtl/mips_dmem_pkg.sv
// rtl/mips_dmem_pkg.sv - shared types and byte-width codes for the data-memory arbiter
package mips_dmem_pkg;

    localparam logic [1:0] BW_WORD = 2'b11;
    localparam logic [1:0] BW_HALF = 2'b10;
    localparam logic [1:0] BW_BYTE = 2'b01;
    localparam logic [1:0] BW_NONE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  bw;
        logic        sext;
    } cmd_t;

endpackage

// File: rtl/mips_rr_arb2.sv
// rtl/mips_rr_arb2.sv - two-way request picker, round-robin or fixed priority to port 0
module mips_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       rr_en_i,
    output logic [1:0] gnt_o
);

    // last_i = 1 means port 1 was granted most recently, so port 0 wins a tie.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (rr_en_i && !last_i) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mips_dmem_arbiter.sv
// rtl/mips_dmem_arbiter.sv - two-port arbiter in front of a single-cycle data memory
module mips_dmem_arbiter
    import mips_dmem_pkg::*;
#(
    parameter logic RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic [1:0]  bw0,
    input  logic        sext0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic [1:0]  bw1,
    input  logic        sext1,
    output logic        gnt0,
    output logic        rvalid0,
    output logic [31:0] rdata0,
    output logic        err0,
    output logic        gnt1,
    output logic        rvalid1,
    output logic [31:0] rdata1,
    output logic        err1,
    output logic [31:0] m_addr,
    output logic [31:0] m_busw,
    output logic        m_wen,
    output logic        m_sext,
    output logic [1:0]  m_bw,
    input  logic [31:0] m_busr,
    input  logic        m_err
);

    state_e      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    logic        win_q, win_d;
    logic        last_q, last_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic [1:0]  pick;
    cmd_t        cmd0, cmd1;
    logic        in_access;
    logic [31:0] resp_data;
    logic        resp_err;

    assign cmd0 = {we0, addr0, wdata0, bw0, sext0};
    assign cmd1 = {we1, addr1, wdata1, bw1, sext1};

    mips_rr_arb2 u_arb (
        .req_i   ({req1, req0}),
        .last_i  (last_q),
        .rr_en_i (RR_EN),
        .gnt_o   (pick)
    );

    assign in_access = (state_q == ST_ACCESS);

    // A bw=00 access never reaches memory and always reports an error.
    assign resp_data = (cmd_q.we || cmd_q.bw == BW_NONE) ? 32'h0 : m_busr;
    assign resp_err  = (cmd_q.bw == BW_NONE) | m_err;

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        win_d    = win_q;
        last_d   = last_q;
        gnt_d    = 2'b00;
        rvalid_d = 2'b00;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (|pick) begin
                    state_d = ST_ACCESS;
                    win_d   = pick[1];
                    last_d  = pick[1];
                    gnt_d   = pick;
                    cmd_d   = pick[1] ? cmd1 : cmd0;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (win_q) begin
                    rdata1_d    = resp_data;
                    err_d[1]    = resp_err;
                    rvalid_d[1] = 1'b1;
                end else begin
                    rdata0_d    = resp_data;
                    err_d[0]    = resp_err;
                    rvalid_d[0] = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            win_q    <= 1'b0;
            last_q   <= 1'b1;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            win_q    <= win_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // rst gates the write strobe combinationally so a reset mid-access cannot corrupt memory.
    assign m_addr = in_access ? cmd_q.addr  : 32'h0;
    assign m_busw = in_access ? cmd_q.wdata : 32'h0;
    assign m_bw   = in_access ? cmd_q.bw    : BW_NONE;
    assign m_sext = in_access & cmd_q.sext;
    assign m_wen  = in_access & cmd_q.we & ~rst & (cmd_q.bw != BW_NONE);

    assign gnt0    = gnt_q[0];
    assign gnt1    = gnt_q[1];
    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];
    assign err0    = err_q[0];
    assign err1    = err_q[1];
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// tb/tb_mips_dmem_arbiter.sv - directed self-checking bench for mips_dmem_arbiter
module tb_mips_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, sext0, req1, we1, sext1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [1:0]  bw0, bw1;

    logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] m_addr, m_busw, m_busr;
    logic        m_wen, m_sext, m_err;
    logic [1:0]  m_bw;

    logic        fp_gnt0, fp_rvalid0, fp_err0, fp_gnt1, fp_rvalid1, fp_err1;
    logic [31:0] fp_rdata0, fp_rdata1, fp_m_addr, fp_m_busw;
    logic        fp_m_wen, fp_m_sext;
    logic [1:0]  fp_m_bw;

    int n_checks = 0;
    int n_errors = 0;
    int wen_cnt  = 0;
    logic        mem_clr;
    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    mips_dmem_arbiter #(.RR_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .bw0(bw0), .sext0(sext0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .bw1(bw1), .sext1(sext1),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
        .m_addr(m_addr), .m_busw(m_busw), .m_wen(m_wen), .m_sext(m_sext), .m_bw(m_bw),
        .m_busr(m_busr), .m_err(m_err)
    );

    mips_dmem_arbiter #(.RR_EN(1'b0)) u_dut_fp (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(1'b0), .addr0(addr0), .wdata0(wdata0), .bw0(bw0), .sext0(sext0),
        .req1(req1), .we1(1'b0), .addr1(addr1), .wdata1(wdata1), .bw1(bw1), .sext1(sext1),
        .gnt0(fp_gnt0), .rvalid0(fp_rvalid0), .rdata0(fp_rdata0), .err0(fp_err0),
        .gnt1(fp_gnt1), .rvalid1(fp_rvalid1), .rdata1(fp_rdata1), .err1(fp_err1),
        .m_addr(fp_m_addr), .m_busw(fp_m_busw), .m_wen(fp_m_wen), .m_sext(fp_m_sext), .m_bw(fp_m_bw),
        .m_busr(32'h0), .m_err(1'b0)
    );

    // Little-endian single-cycle memory: combinational read, write on posedge.
    logic [31:0] mword;
    logic [15:0] mhalf;
    logic [7:0]  mbyte;
    always_comb begin
        mword  = mem[m_addr[7:2]];
        mhalf  = m_addr[1] ? mword[31:16] : mword[15:0];
        mbyte  = mword[{m_addr[1:0], 3'b000} +: 8];
        m_busr = 32'h0;
        m_err  = 1'b0;
        case (m_bw)
            2'b11: begin m_err = (m_addr[1:0] != 2'b00); m_busr = mword; end
            2'b10: begin m_err = m_addr[0]; m_busr = m_sext ? {{16{mhalf[15]}}, mhalf} : {16'h0, mhalf}; end
            2'b01: m_busr = m_sext ? {{24{mbyte[7]}}, mbyte} : {24'h0, mbyte};
            default: m_busr = 32'h0;
        endcase
        if (m_err) m_busr = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (m_wen && !m_err) begin
            case (m_bw)
                2'b11: mem[m_addr[7:2]] <= m_busw;
                2'b10: mem[m_addr[7:2]][{m_addr[1], 4'b0000} +: 16] <= m_busw[15:0];
                2'b01: mem[m_addr[7:2]][{m_addr[1:0], 3'b000} +: 8] <= m_busw[7:0];
                default: ;
            endcase
        end
        if (m_wen) wen_cnt <= wen_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_access(input int port, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] bw, input logic sext,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_wen, input string tag);
        int          wen_before;
        logic [31:0] other_before;
        wen_before   = wen_cnt;
        other_before = (port == 1) ? rdata0 : rdata1;
        if (port == 0) begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; bw0 = bw; sext0 = sext;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; bw1 = bw; sext1 = sext;
        end
        @(posedge clk); #1;
        check({tag, "_gnt"}, (port == 1) ? gnt1 : gnt0, 1);
        check({tag, "_wen_access"}, m_wen, (exp_wen != 0));
        req0 = 1'b0; req1 = 1'b0;
        addr0 = 32'hxxxx_xxxx; addr1 = 32'hxxxx_xxxx;
        @(posedge clk); #1;
        check({tag, "_rvalid"}, (port == 1) ? rvalid1 : rvalid0, 1);
        check({tag, "_rdata"}, (port == 1) ? rdata1 : rdata0, exp_rdata);
        check({tag, "_err"}, (port == 1) ? err1 : err0, exp_err);
        check({tag, "_gnt_pulse"}, {gnt1, gnt0}, 0);
        check({tag, "_wen_resp"}, m_wen, 0);
        check({tag, "_wen_count"}, wen_cnt - wen_before, exp_wen);
        check({tag, "_other_hold"}, (port == 1) ? rdata0 : rdata1, other_before);
        @(posedge clk); #1;
        check({tag, "_rvalid_pulse"}, {rvalid1, rvalid0}, 0);
        addr0 = 32'h0; addr1 = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int          rr_seq[$];
    int          fp_seq[$];
    int          wen_snap;

    initial begin
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; bw0 = 2'b11; sext0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; bw1 = 2'b11; sext1 = 0;
        mem_clr = 1'b1;
        do_reset();
        mem_clr = 1'b0;

        check("reset_gnt", {gnt1, gnt0}, 0);
        check("reset_rvalid", {rvalid1, rvalid0}, 0);
        check("reset_rdata0", rdata0, 0);
        check("reset_rdata1", rdata1, 0);
        check("reset_err", {err1, err0}, 0);
        check("reset_m_addr", m_addr, 0);
        check("reset_m_wen", m_wen, 0);
        check("reset_m_bw", m_bw, 0);

        run_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b11, 1'b0, 32'h0,        1'b0, 1, "wr_word");
        run_access(0, 1'b0, 32'h10, 32'h0,        2'b11, 1'b0, 32'hDEADBEEF, 1'b0, 0, "rd_word");
        run_access(1, 1'b0, 32'h12, 32'h0,        2'b11, 1'b0, 32'h0,        1'b1, 0, "rd_misalign");

        run_access(1, 1'b1, 32'h00, 32'h000080FF, 2'b11, 1'b0, 32'h0,        1'b0, 1, "wr_80ff");
        run_access(0, 1'b0, 32'h01, 32'h0,        2'b01, 1'b1, 32'hFFFFFF80, 1'b0, 0, "rd_byte_sext");
        run_access(0, 1'b0, 32'h01, 32'h0,        2'b01, 1'b0, 32'h00000080, 1'b0, 0, "rd_byte_zext");
        run_access(1, 1'b0, 32'h00, 32'h0,        2'b10, 1'b1, 32'hFFFF80FF, 1'b0, 0, "rd_half_sext");

        run_access(0, 1'b1, 32'h10, 32'h11111111, 2'b00, 1'b0, 32'h0,        1'b1, 0, "wr_bw00");
        run_access(0, 1'b0, 32'h10, 32'h0,        2'b11, 1'b0, 32'hDEADBEEF, 1'b0, 0, "rd_after_bw00");

        // Reset asserted during the ACCESS cycle of a write.
        wen_snap = wen_cnt;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h12345678; bw0 = 2'b11;
        @(posedge clk); #1;
        check("rst_acc_gnt", gnt0, 1);
        req0 = 1'b0; rst = 1'b1;
        #1;
        check("rst_acc_wen", m_wen, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_acc_rvalid", {rvalid1, rvalid0}, 0);
        check("rst_acc_wen_count", wen_cnt - wen_snap, 0);
        check("rst_acc_mem", mem[8], 32'h0);
        run_access(0, 1'b0, 32'h20, 32'h0, 2'b11, 1'b0, 32'h0, 1'b0, 0, "rd_after_rst");

        // Both ports requesting continuously from reset.
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; bw0 = 2'b11;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10; bw1 = 2'b11;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (gnt0) rr_seq.push_back(0);
            if (gnt1) rr_seq.push_back(1);
            if (fp_gnt0) fp_seq.push_back(0);
            if (fp_gnt1) fp_seq.push_back(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr_count", rr_seq.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_grant%0d", i), (i < rr_seq.size()) ? rr_seq[i] : 99, i % 2);
        check("fp_count", fp_seq.size(), 4);
        for (int i = 0; i < 3; i++)
            check($sformatf("fp_grant%0d", i), (i < fp_seq.size()) ? fp_seq[i] : 99, 0);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
